// File: rtl/regfile_bypass_sb.sv
// regfile_bypass_sb: N-read/1-write register file with write-through bypass and busy scoreboard (debug ports via REGFILE_DEBUG_PORT_EN)
module regfile_bypass_sb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     stall,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr
`ifdef REGFILE_DEBUG_PORT_EN
  ,
  output logic [NUM_REGS*DATA_W-1:0] dbg_regs,
  output logic [NUM_REGS-1:0]        dbg_busy
`endif
);
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (we && wr_addr != '0) regs_d[wr_addr] = wr_data;
    if (we) busy_d[wr_addr] = 1'b0;
    // issue after writeback so a new producer on the same index wins
    if (iss_valid && iss_addr != '0) busy_d[iss_addr] = 1'b1;
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit;
    assign ra  = rd_addr[p*ADDR_W +: ADDR_W];
    assign hit = we && wr_addr == ra;
    assign rd_data[p*DATA_W +: DATA_W] = ra == '0 ? '0 : hit ? wr_data : regs_q[ra];
    assign rd_busy[p] = busy_q[ra] & ~hit;
  end
  assign stall = |(rd_en & rd_busy);
`ifdef REGFILE_DEBUG_PORT_EN
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_dbg
    assign dbg_regs[r*DATA_W +: DATA_W] = regs_q[r];
  end
  assign dbg_busy = busy_q;
`endif
endmodule

// File: tb/tb_regfile_bypass_sb.sv
// tb_regfile_bypass_sb: directed vector table plus randomized run against a behavioural register-file model
module tb_regfile_bypass_sb;
  localparam int DW = 32, NR = 32, AW = 5, NP = 2;
  logic clk = 1'b0, rst, we, iss_valid, stall;
  logic [NP-1:0] rd_en, rd_busy;
  logic [NP*AW-1:0] rd_addr;
  logic [NP*DW-1:0] rd_data;
  logic [AW-1:0] wr_addr, iss_addr;
  logic [DW-1:0] wr_data;
`ifdef REGFILE_DEBUG_PORT_EN
  logic [NR*DW-1:0] dbg_regs;
  logic [NR-1:0] dbg_busy;
`endif
  regfile_bypass_sb #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NP)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .stall(stall), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr)
`ifdef REGFILE_DEBUG_PORT_EN
    , .dbg_regs(dbg_regs), .dbg_busy(dbg_busy)
`endif
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_err = 0;
  task automatic chk(input string n, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h expected %h", n, idx, act, exp);
    end
  endtask
  typedef struct {
    logic rst, we; logic [4:0] wa; logic [31:0] wd; logic iv; logic [4:0] ia;
    logic [1:0] en; logic [4:0] a0, a1; logic [31:0] d0, d1; logic [1:0] bz; logic st;
  } vec_t;
  function automatic vec_t mk(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                              input logic iv, input logic [4:0] ia, input logic [1:0] en,
                              input logic [4:0] a0, input logic [4:0] a1, input logic [31:0] d0,
                              input logic [31:0] d1, input logic [1:0] bz, input logic st);
    vec_t v;
    v.rst = r; v.we = w; v.wa = wa; v.wd = wd; v.iv = iv; v.ia = ia; v.en = en;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.bz = bz; v.st = st;
    return v;
  endfunction
  vec_t tv [21];
  logic [31:0] m_regs [NR];
  logic        m_busy [NR];
  function automatic logic [4:0] raddr();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction
  initial begin
    // rst we wa wd iv ia en a0 a1 | d0 d1 busy stall
    tv[0]  = mk(1'b0,1'b1,5'd5,32'hDEADBEEF,1'b0,5'd0,2'b11,5'd5,5'd5,32'hDEADBEEF,32'hDEADBEEF,2'b00,1'b0);
    tv[1]  = mk(1'b0,1'b0,5'd0,32'h0,1'b0,5'd0,2'b11,5'd5,5'd0,32'hDEADBEEF,32'h0,2'b00,1'b0);
    tv[2]  = mk(1'b1,1'b0,5'd0,32'h0,1'b0,5'd0,2'b11,5'd5,5'd5,32'hDEADBEEF,32'hDEADBEEF,2'b00,1'b0);
    tv[3]  = mk(1'b1,1'b0,5'd0,32'h0,1'b0,5'd0,2'b11,5'd5,5'd5,32'h0,32'h0,2'b00,1'b0);
    tv[4]  = mk(1'b0,1'b0,5'd0,32'h0,1'b0,5'd0,2'b11,5'd5,5'd5,32'h0,32'h0,2'b00,1'b0);
    tv[5]  = mk(1'b0,1'b1,5'd0,32'hFFFFFFFF,1'b1,5'd0,2'b11,5'd0,5'd0,32'h0,32'h0,2'b00,1'b0);
    tv[6]  = mk(1'b0,1'b0,5'd0,32'h0,1'b0,5'd0,2'b11,5'd0,5'd0,32'h0,32'h0,2'b00,1'b0);
    tv[7]  = mk(1'b0,1'b1,5'd7,32'h11,1'b0,5'd0,2'b00,5'd7,5'd7,32'h11,32'h11,2'b00,1'b0);
    tv[8]  = mk(1'b0,1'b1,5'd7,32'h22,1'b0,5'd0,2'b00,5'd7,5'd7,32'h22,32'h22,2'b00,1'b0);
    tv[9]  = mk(1'b0,1'b0,5'd0,32'h0,1'b0,5'd0,2'b00,5'd7,5'd7,32'h22,32'h22,2'b00,1'b0);
    tv[10] = mk(1'b0,1'b0,5'd0,32'h0,1'b1,5'd9,2'b01,5'd9,5'd0,32'h0,32'h0,2'b00,1'b0);
    tv[11] = mk(1'b0,1'b0,5'd0,32'h0,1'b0,5'd0,2'b01,5'd9,5'd9,32'h0,32'h0,2'b11,1'b1);
    tv[12] = mk(1'b0,1'b0,5'd0,32'h0,1'b0,5'd0,2'b00,5'd9,5'd9,32'h0,32'h0,2'b11,1'b0);
    tv[13] = mk(1'b0,1'b1,5'd9,32'hA5,1'b0,5'd0,2'b11,5'd9,5'd9,32'hA5,32'hA5,2'b00,1'b0);
    tv[14] = mk(1'b0,1'b0,5'd0,32'h0,1'b0,5'd0,2'b11,5'd9,5'd9,32'hA5,32'hA5,2'b00,1'b0);
    tv[15] = mk(1'b0,1'b0,5'd0,32'h0,1'b1,5'd3,2'b00,5'd0,5'd0,32'h0,32'h0,2'b00,1'b0);
    tv[16] = mk(1'b0,1'b1,5'd3,32'h77,1'b1,5'd3,2'b01,5'd3,5'd7,32'h77,32'h22,2'b00,1'b0);
    tv[17] = mk(1'b0,1'b0,5'd0,32'h0,1'b0,5'd0,2'b01,5'd3,5'd7,32'h77,32'h22,2'b01,1'b1);
    tv[18] = mk(1'b0,1'b0,5'd0,32'h0,1'b1,5'd4,2'b00,5'd0,5'd0,32'h0,32'h0,2'b00,1'b0);
    tv[19] = mk(1'b1,1'b1,5'd4,32'h55,1'b0,5'd0,2'b01,5'd4,5'd3,32'h55,32'h77,2'b10,1'b0);
    tv[20] = mk(1'b0,1'b0,5'd0,32'h0,1'b0,5'd0,2'b11,5'd4,5'd3,32'h0,32'h0,2'b00,1'b0);
    rst = 1'b1; we = 1'b0; wr_addr = '0; wr_data = '0; iss_valid = 1'b0; iss_addr = '0;
    rd_en = '0; rd_addr = '0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst = 1'b0; rd_en = 2'b11; rd_addr = {raddr(), raddr()};
      #1;
      chk("reset_data", i, rd_data[31:0] | rd_data[63:32], 32'h0);
      chk("reset_busy_stall", i, {29'h0, rd_busy, stall}, 32'h0);
    end
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      rst = tv[i].rst; we = tv[i].we; wr_addr = tv[i].wa; wr_data = tv[i].wd;
      iss_valid = tv[i].iv; iss_addr = tv[i].ia; rd_en = tv[i].en; rd_addr = {tv[i].a1, tv[i].a0};
      #1;
      chk("vec_d0", i, rd_data[31:0], tv[i].d0);
      chk("vec_d1", i, rd_data[63:32], tv[i].d1);
      chk("vec_busy", i, {30'h0, rd_busy}, {30'h0, tv[i].bz});
      chk("vec_stall", i, {31'h0, stall}, {31'h0, tv[i].st});
    end
    @(negedge clk);
    rst = 1'b0; we = 1'b0; iss_valid = 1'b0; rd_en = '0;
`ifdef REGFILE_DEBUG_PORT_EN
    n_cmp++;
    if (dbg_regs !== '0 || dbg_busy !== '0) begin
      n_err++;
      $display("FAIL dbg_after_reset: busy %h expected 0, regs nonzero", dbg_busy);
    end
`endif
    for (int r = 0; r < NR; r++) begin m_regs[r] = '0; m_busy[r] = 1'b0; end
    for (int c = 0; c < 3000; c++) begin
      logic [1:0] eb;
      logic es;
      @(negedge clk);
      rst = ($urandom_range(0, 63) == 0);
      we = 1'($urandom_range(0, 1)); wr_addr = raddr(); wr_data = $urandom;
      iss_valid = 1'($urandom_range(0, 1)); iss_addr = raddr();
      rd_en = 2'($urandom_range(0, 3)); rd_addr = {raddr(), raddr()};
      if ($urandom_range(0, 3) == 0) rd_addr[9:5] = rd_addr[4:0];
      #1;
      es = 1'b0;
      for (int p = 0; p < NP; p++) begin
        logic [4:0] a;
        logic hit;
        a = rd_addr[p*AW +: AW];
        hit = we && wr_addr == a;
        chk("rand_data", c, rd_data[p*DW +: DW], a == 0 ? 32'h0 : hit ? wr_data : m_regs[a]);
        eb[p] = m_busy[a] && !hit;
        es = es | (rd_en[p] && eb[p]);
      end
      chk("rand_busy", c, {30'h0, rd_busy}, {30'h0, eb});
      chk("rand_stall", c, {31'h0, stall}, {31'h0, es});
`ifdef REGFILE_DEBUG_PORT_EN
      for (int r = 0; r < NR; r++) begin
        chk("rand_dbg_regs", r, dbg_regs[r*DW +: DW], m_regs[r]);
        chk("rand_dbg_busy", r, {31'h0, dbg_busy[r]}, {31'h0, m_busy[r]});
      end
`endif
      if (rst) begin
        for (int r = 0; r < NR; r++) begin m_regs[r] = '0; m_busy[r] = 1'b0; end
      end else begin
        if (we && wr_addr != 0) m_regs[wr_addr] = wr_data;
        if (we) m_busy[wr_addr] = 1'b0;
        if (iss_valid && iss_addr != 0) m_busy[iss_addr] = 1'b1;
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
